// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with registered read data, occupancy flags and count.
// Define FIFO_ERR_FLAGS_EN to build sticky overflow/underflow flags; otherwise they are tied to 0.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [DATA_W-1:0]          din,
    input  logic                       rd,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic              wr_ok, rd_ok;

    assign full         = count == CW'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= CW'(AF_THRESH);
    assign almost_empty = count <= CW'(AE_THRESH);
    // a simultaneous read frees the slot, so a write into a full FIFO is still accepted
    assign rd_ok        = rd && !empty;
    assign wr_ok        = wr && (!full || rd);

    always_ff @(posedge clk)
        if (wr_ok && !rst)
            mem[wptr] <= din;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            dout  <= '0;
        end else begin
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (rd_ok) begin
                dout <= mem[rptr];
                rptr <= rptr + 1'b1;
            end
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (wr && full && !rd);
            underflow <= underflow | (rd && empty);
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized and directed checks of sync_fifo_param against a queue model.
module tb_sync_fifo_param;
    logic       clk = 0, rst = 1, wr = 0, rd = 0;
    logic [7:0] din = 0, dout;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic [7:0] q[$];
    logic [7:0] mdout = 0;
    logic       mov = 0, mun = 0;
    int         checks = 0, failures = 0;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .dout(dout),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // one clock of stimulus; the model applies the FIFO rules to the pre-edge occupancy
    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic rs = 0);
        logic racc, wacc;
        wr = w; rd = r; din = d; rst = rs;
        @(posedge clk);
        if (rs) begin
            q.delete(); mdout = 0; mov = 0; mun = 0;
        end else begin
            racc = r && q.size() > 0;
            wacc = w && (q.size() < 16 || r);
`ifdef FIFO_ERR_FLAGS_EN
            if (w && q.size() == 16 && !r) mov = 1;
            if (r && q.size() == 0) mun = 1;
`endif
            if (racc) mdout = q.pop_front();
            if (wacc) q.push_back(d);
        end
        #1;
        wr = 0; rd = 0; rst = 0;
    endtask

    task automatic test_reset;
        cyc(0, 0, 0, 1);
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b/%b exp=1/1", empty, almost_empty); end
        checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b/%b exp=0/0", full, almost_full); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b/%b exp=0/0", overflow, underflow); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 8'(i));
            checks++; if (count !== 5'(i + 1)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
            checks++; if (almost_full !== (i + 1 >= 14)) begin failures++; $display("FAIL fill_af got=%b exp=%b at %0d", almost_full, i + 1 >= 14, i + 1); end
            checks++; if (full !== (i == 15)) begin failures++; $display("FAIL fill_full got=%b exp=%b at %0d", full, i == 15, i + 1); end
        end
        cyc(1, 0, 8'hEE);
        checks++; if (count !== 5'd16 || full !== 1'b1) begin failures++; $display("FAIL fill_drop got=%0d/%b exp=16/1", count, full); end
        checks++; if (overflow !== mov) begin failures++; $display("FAIL fill_overflow got=%b exp=%b", overflow, mov); end
    endtask

    task automatic test_drain;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0);
            checks++; if (dout !== 8'(i) || dout !== mdout) begin failures++; $display("FAIL drain_dout got=%h exp=%h", dout, 8'(i)); end
            checks++; if (almost_empty !== (15 - i <= 2)) begin failures++; $display("FAIL drain_ae got=%b exp=%b at %0d", almost_empty, 15 - i <= 2, 15 - i); end
        end
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, count); end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h40 + i));
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 8'(8'h50 + i));
            checks++; if (count !== 5'd16) begin failures++; $display("FAIL wrap_count got=%0d exp=16", count); end
            checks++; if (dout !== mdout || dout !== 8'(8'h40 + i)) begin failures++; $display("FAIL wrap_dout got=%h exp=%h", dout, 8'(8'h40 + i)); end
        end
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0);
            checks++; if (dout !== 8'(8'h68 + i)) begin failures++; $display("FAIL wrap_drain got=%h exp=%h", dout, 8'(8'h68 + i)); end
        end
    endtask

    task automatic test_empty_rw;
        cyc(0, 0, 0, 1);
        cyc(1, 0, 8'h11);
        cyc(0, 1, 0);
        cyc(1, 1, 8'hA5);
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL erw_count got=%0d exp=1", count); end
        checks++; if (dout !== 8'h11) begin failures++; $display("FAIL erw_dout got=%h exp=11", dout); end
        checks++; if (underflow !== mun) begin failures++; $display("FAIL erw_underflow got=%b exp=%b", underflow, mun); end
        cyc(0, 1, 0);
        checks++; if (dout !== 8'hA5) begin failures++; $display("FAIL erw_read got=%h exp=a5", dout); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'($urandom));
        cyc(0, 1, 0);
        cyc(1, 0, 8'h77, 1);
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL rmid_count got=%0d/%b exp=0/1", count, empty); end
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rmid_dout got=%h exp=00", dout); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL rmid_flags got=%b/%b exp=0/0", overflow, underflow); end
        cyc(1, 0, 8'h3C);
        cyc(0, 1, 0);
        checks++; if (dout !== 8'h3C) begin failures++; $display("FAIL rmid_3c got=%h exp=3c", dout); end
    endtask

    task automatic test_err_flags;
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0);
        checks++; if (underflow !== mun || count !== 5'd0 || dout !== 8'h00) begin failures++; $display("FAIL err_under got=%b/%0d/%h exp=%b/0/00", underflow, count, dout, mun); end
        for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h90 + i));
        cyc(1, 0, 8'hFF);
        checks++; if (overflow !== mov || count !== 5'd16) begin failures++; $display("FAIL err_over got=%b/%0d exp=%b/16", overflow, count, mov); end
        cyc(0, 1, 0);
        checks++; if (dout !== 8'h90 || overflow !== mov || underflow !== mun) begin failures++; $display("FAIL err_sticky got=%h/%b/%b exp=90/%b/%b", dout, overflow, underflow, mov, mun); end
    endtask

    task automatic test_random;
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 99) < (i < 200 ? 70 : 35)), 1'($urandom_range(0, 99) < 50), 8'($urandom));
            checks++; if (count !== 5'(q.size()) || dout !== mdout) begin failures++; $display("FAIL rand_state got=%0d/%h exp=%0d/%h", count, dout, q.size(), mdout); end
            checks++; if (full !== (q.size() == 16) || empty !== (q.size() == 0) || almost_full !== (q.size() >= 14) || almost_empty !== (q.size() <= 2)) begin failures++; $display("FAIL rand_flags got=%b%b%b%b size=%0d", full, empty, almost_full, almost_empty, q.size()); end
            checks++; if (overflow !== mov || underflow !== mun) begin failures++; $display("FAIL rand_err got=%b/%b exp=%b/%b", overflow, underflow, mov, mun); end
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_drain;
        test_wrap;
        test_empty_rw;
        test_reset_mid;
        test_err_flags;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
